// File: rtl/rr_arbiter_4_1.sv
// Four-channel round-robin arbiter feeding a single-entry valid/ready output register.
// The channel most recently accepted drops to lowest priority on the next arbitration.
module rr_arbiter_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic [1:0]   sel,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src,
    input  logic         out_ready
);

    logic [1:0]   last_grant_reg, last_grant_next;
    logic         out_valid_reg,  out_valid_next;
    logic [W-1:0] out_data_reg,   out_data_next;
    logic [1:0]   out_src_reg,    out_src_next;

    logic [W-1:0] chan_data [4];
    logic [1:0]   cand      [4];
    logic [3:0]   cand_hit;
    logic [1:0]   grant_idx;
    logic         can_load;
    logic         transfer;
    logic [W-1:0] grant_data;

    assign chan_data[0] = in_data0;
    assign chan_data[1] = in_data1;
    assign chan_data[2] = in_data2;
    assign chan_data[3] = in_data3;

    // cand[k] is the channel holding priority rank k (0 = highest) this cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rank
            assign cand[gi]     = last_grant_reg + 2'(gi + 1);
            assign cand_hit[gi] = in_valid[cand[gi]];
        end
    endgenerate

    // Walk ranks from lowest to highest so the best-ranked requester wins;
    // with no requester the pointer rests on last_grant+1.
    always_comb begin
        grant_idx = cand[0];
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_idx = cand[k];
            end
        end
    end

    assign can_load = !out_valid_reg || out_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ready
            assign in_ready[gi] = can_load && in_valid[gi] && (grant_idx == 2'(gi));
        end
    endgenerate

    assign transfer   = |in_ready;
    assign grant_data = chan_data[grant_idx];

    // Ungranted channel data is never selected, so its value cannot reach out_data.
    always_comb begin
        last_grant_next = last_grant_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_src_next    = out_src_reg;
        if (transfer) begin
            out_valid_next  = 1'b1;
            out_data_next   = grant_data;
            out_src_next    = grant_idx;
            last_grant_next = grant_idx;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 2'd3;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_src_reg    <= 2'd0;
        end else begin
            last_grant_reg <= last_grant_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_src_reg    <= out_src_next;
        end
    end

    assign sel       = grant_idx;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

endmodule

// File: tb/tb_rr_arbiter_4_1.sv
// Scoreboard bench for rr_arbiter_4_1: directed vectors push expected words,
// a negedge monitor pops and compares each word the consumer accepts.
module tb_rr_arbiter_4_1;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   src;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rr_arbiter_4_1 #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .in_data3 (in_data3),
        .in_ready (in_ready),
        .sel      (sel),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: each consumer handshake pops one expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got data=%0h src=%0d expected none", out_data, out_src);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_src !== e.src) begin
                    bad++;
                    $display("FAIL word: got data=%0h src=%0d expected data=%0h src=%0d",
                             out_data, out_src, e.data, e.src);
                end else begin
                    $display("word ok: data=%0h src=%0d", out_data, out_src);
                end
            end
        end
    end

    // One cycle: drive at posedge+1, check combinational outputs at negedge,
    // push the expected word when a transfer is expected, return at next posedge+1.
    task automatic step(input logic [3:0] v, input logic ordy, input logic [1:0] esel,
                        input logic [3:0] erdy, input logic [W-1:0] edata, input logic ev);
        exp_t e;
        in_valid  = v;
        out_ready = ordy;
        @(negedge clk);
        $display("cycle: in_valid=%b out_ready=%b sel=%0d in_ready=%b out_valid=%b",
                 v, ordy, sel, in_ready, out_valid);
        check("sel", 32'(sel), 32'(esel));
        check("in_ready", 32'(in_ready), 32'(erdy));
        check("out_valid", 32'(out_valid), 32'(ev));
        if (erdy != 4'b0000) begin
            e.data = edata;
            e.src  = esel;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data0  = 4'h1;
        in_data1  = 4'h2;
        in_data2  = 4'h3;
        in_data3  = 4'h4;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_sel_idle", 32'(sel), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four requesting: rotate 0..3 twice with no bubbles.
        step(4'b1111, 1'b1, 2'd0, 4'b0001, 4'h1, 1'b0);
        step(4'b1111, 1'b1, 2'd1, 4'b0010, 4'h2, 1'b1);
        step(4'b1111, 1'b1, 2'd2, 4'b0100, 4'h3, 1'b1);
        step(4'b1111, 1'b1, 2'd3, 4'b1000, 4'h4, 1'b1);
        step(4'b1111, 1'b1, 2'd0, 4'b0001, 4'h1, 1'b1);
        step(4'b1111, 1'b1, 2'd1, 4'b0010, 4'h2, 1'b1);
        step(4'b1111, 1'b1, 2'd2, 4'b0100, 4'h3, 1'b1);
        step(4'b1111, 1'b1, 2'd3, 4'b1000, 4'h4, 1'b1);

        // Park last_grant on 0, then two requesters alternate 2,0,2.
        step(4'b0001, 1'b1, 2'd0, 4'b0001, 4'h1, 1'b1);
        step(4'b0101, 1'b1, 2'd2, 4'b0100, 4'h3, 1'b1);
        step(4'b0101, 1'b1, 2'd0, 4'b0001, 4'h1, 1'b1);
        step(4'b0101, 1'b1, 2'd2, 4'b0100, 4'h3, 1'b1);

        // Stall with channel 1 waiting: register and grant pointer frozen.
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 1'b0, 2'd1, 4'b0000, 4'h0, 1'b1);
            check("stall_out_data", 32'(out_data), 32'h3);
            check("stall_out_src", 32'(out_src), 32'd2);
        end
        // Release: drain and load in the same cycle.
        step(4'b0010, 1'b1, 2'd1, 4'b0010, 4'h2, 1'b1);

        // Unknown data on an ungranted channel must not leak.
        in_data0 = 'x;
        in_data3 = 4'h7;
        step(4'b1000, 1'b1, 2'd3, 4'b1000, 4'h7, 1'b1);
        in_data0 = 4'h1;

        // Hold word 7 with the consumer stalled, then reset asynchronously.
        step(4'b0001, 1'b0, 2'd0, 4'b0000, 4'h0, 1'b1);
        check("pre_rst_out_data", 32'(out_data), 32'h7);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(4'b1111, 1'b1, 2'd0, 4'b0001, 4'h1, 1'b0);
        step(4'b0000, 1'b1, 2'd1, 4'b0000, 4'h0, 1'b1);
        step(4'b0000, 1'b1, 2'd1, 4'b0000, 4'h0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
